// File: rtl/spi_slave_sync.sv
// SPI slave, oversampled on clk, any CPOL/CPHA, DATA_W-bit words, multi-word frames.
// Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_slave_sync #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun
);

    localparam int   CW        = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic IDLE_SCLK = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction
    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] w);
        return {1'b0, w[DATA_W-1:1]};
    endfunction
    function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] w, input logic b);
        return {b, w[DATA_W-1:1]};
    endfunction
`else
    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], 1'b0};
    endfunction
    function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] w, input logic b);
        return {w[DATA_W-2:0], b};
    endfunction
`endif

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;

    // cs chain resets low so a select already held low at reset release never looks like a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= IDLE_SCLK;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    logic rise, fall, lead, trail, sample_edge, shift_edge, cs_fall, cs_rise;
    assign rise        = sclk_s & ~sclk_d;
    assign fall        = ~sclk_s & sclk_d;
    assign lead        = (CPOL == 0) ? rise : fall;
    assign trail       = (CPOL == 0) ? fall : rise;
    assign sample_edge = (CPHA == 0) ? lead : trail;
    assign shift_edge  = (CPHA == 0) ? trail : lead;
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;

    state_t state_q, state_d;
    logic   enter, leave, do_sample, do_shift;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // cs rising masks any sclk edge seen in the same cycle
    always_comb begin
        state_d   = state_q;
        enter     = 1'b0;
        leave     = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                state_d = ACTIVE;
                enter   = 1'b1;
            end
            ACTIVE: if (cs_rise) begin
                state_d = IDLE;
                leave   = 1'b1;
            end else begin
                do_sample = sample_edge;
                do_shift  = shift_edge;
            end
            default: state_d = IDLE;
        endcase
    end

    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sh, tx_hold, rx_sh, load_word;
    logic              tx_full, pend, rx_done, last_bit, load_now;

    assign last_bit  = (bit_cnt == CW'(DATA_W-1));
    assign load_word = tx_full ? tx_hold : '0;
    // CPHA=0 preloads at word completion; CPHA=1 defers to the next word's first shift edge
    assign load_now  = enter | ((CPHA == 0) ? (do_sample & last_bit) : (do_shift & pend));
    assign tx_ready  = ~tx_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            tx_sh       <= '0;
            tx_hold     <= '0;
            tx_full     <= 1'b0;
            rx_sh       <= '0;
            pend        <= 1'b0;
            rx_done     <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_done     <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= load_now & ~tx_full;

            if (tx_valid && !tx_full) begin
                tx_hold <= tx_data;
                tx_full <= 1'b1;
            end else if (load_now) begin
                tx_full <= 1'b0;
            end

            if (enter) begin
                bit_cnt <= '0;
                miso_oe <= 1'b1;
                pend    <= 1'b0;
                if (CPHA == 0) begin
                    miso  <= tx_bit(load_word);
                    tx_sh <= tx_adv(load_word);
                end else begin
                    miso  <= 1'b0;
                    tx_sh <= load_word;
                end
            end else if (leave) begin
                bit_cnt <= '0;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
                pend    <= 1'b0;
            end else begin
                if (do_sample) begin
                    rx_sh <= rx_ins(rx_sh, mosi_s);
                    if (last_bit) begin
                        bit_cnt <= '0;
                        rx_done <= 1'b1;
                        if (CPHA == 0) tx_sh <= load_word;
                        else           pend  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (do_shift) begin
                    if (CPHA != 0 && pend) begin
                        miso  <= tx_bit(load_word);
                        tx_sh <= tx_adv(load_word);
                        pend  <= 1'b0;
                    end else begin
                        miso  <= tx_bit(tx_sh);
                        tx_sh <= tx_adv(tx_sh);
                    end
                end
            end

            if (rx_done) begin
                rx_data    <= rx_sh;
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: one instance per SPI mode (index = CPOL*2+CPHA), rx scoreboard queue.
module tb_spi_slave_sync;

    localparam int H = 8;

    logic            clk, rst;
    logic [3:0]      sclk, cs_n, mosi, miso, miso_oe;
    logic [3:0]      tx_valid, tx_ready, tx_underrun, rx_valid, rx_ready, rx_overrun;
    logic [3:0][7:0] tx_data, rx_data;

    int          n_tests = 0, n_fail = 0;
    int          cur = 0, und_cnt = 0, ovr_cnt = 0;
    logic [7:0]  rxq[$];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_slave_sync #(.DATA_W(8), .CPOL(m / 2), .CPHA(m % 2), .SYNC_STAGES(2)) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk[m]), .cs_n(cs_n[m]), .mosi(mosi[m]),
            .miso(miso[m]), .miso_oe(miso_oe[m]),
            .tx_data(tx_data[m]), .tx_valid(tx_valid[m]), .tx_ready(tx_ready[m]),
            .tx_underrun(tx_underrun[m]),
            .rx_data(rx_data[m]), .rx_valid(rx_valid[m]), .rx_ready(rx_ready[m]),
            .rx_overrun(rx_overrun[m])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rx monitor: every accepted word must match the oldest expected word
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid[cur] && rx_ready[cur]) begin
                n_tests++;
                if (rxq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rx_unexpected mode%0d: got %h, expected no word", cur, rx_data[cur]);
                end else if (rx_data[cur] !== rxq[0]) begin
                    n_fail++;
                    $display("FAIL rx_data mode%0d: got %h, expected %h", cur, rx_data[cur], rxq[0]);
                    void'(rxq.pop_front());
                end else begin
                    void'(rxq.pop_front());
                end
            end
            if (tx_underrun[cur]) und_cnt++;
            if (rx_overrun[cur])  ovr_cnt++;
        end
    end

    task automatic tx_put(input int m, input logic [7:0] d);
        int k = 0;
        while (!tx_ready[m] && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready[m]) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_ready_timeout mode%0d: tx_ready=%b, expected 1", m, tx_ready[m]);
        end
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_high(input int m);
        repeat (H) @(negedge clk);
        cs_n[m] = 1'b1;
        repeat (2 * H) @(negedge clk);
    endtask

    // master side of nbits bits; optionally queues the rx word and checks the miso word
    task automatic spi_word(input int m, input logic [7:0] mo, input int nbits,
                            input logic push, input logic chk, input logic [7:0] exp_mi);
        logic [7:0] mi;
        logic       cpol, cpha;
        int         idx;
        cpol = ((m / 2) != 0);
        cpha = ((m % 2) != 0);
        mi   = '0;
        if (push) rxq.push_back(mo);
        for (int i = 0; i < nbits; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            if (!cpha) begin
                mosi[m] = mo[idx];
                repeat (H) @(negedge clk);
                mi[idx] = miso[m];
                sclk[m] = ~cpol;
                repeat (H) @(negedge clk);
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = mo[idx];
                repeat (H) @(negedge clk);
                mi[idx] = miso[m];
                sclk[m] = cpol;
                repeat (H) @(negedge clk);
            end
        end
        if (chk) begin
            n_tests++;
            if (mi !== exp_mi) begin
                n_fail++;
                $display("FAIL miso_word mode%0d: got %h, expected %h", m, mi, exp_mi);
            end
        end
    endtask

    task automatic test_reset();
        for (int m = 0; m < 4; m++) begin
            n_tests += 7;
            if (miso[m] !== 1'b0)        begin n_fail++; $display("FAIL rst_miso mode%0d: got %b, expected 0", m, miso[m]); end
            if (miso_oe[m] !== 1'b0)     begin n_fail++; $display("FAIL rst_miso_oe mode%0d: got %b, expected 0", m, miso_oe[m]); end
            if (tx_ready[m] !== 1'b1)    begin n_fail++; $display("FAIL rst_tx_ready mode%0d: got %b, expected 1", m, tx_ready[m]); end
            if (tx_underrun[m] !== 1'b0) begin n_fail++; $display("FAIL rst_tx_underrun mode%0d: got %b, expected 0", m, tx_underrun[m]); end
            if (rx_data[m] !== 8'h00)    begin n_fail++; $display("FAIL rst_rx_data mode%0d: got %h, expected 00", m, rx_data[m]); end
            if (rx_valid[m] !== 1'b0)    begin n_fail++; $display("FAIL rst_rx_valid mode%0d: got %b, expected 0", m, rx_valid[m]); end
            if (rx_overrun[m] !== 1'b0)  begin n_fail++; $display("FAIL rst_rx_overrun mode%0d: got %b, expected 0", m, rx_overrun[m]); end
        end
    endtask

    task automatic test_single_word(input int m);
        cur = m;
        tx_put(m, 8'hA5);
        cs_low(m);
        n_tests++;
        if (miso_oe[m] !== 1'b1) begin n_fail++; $display("FAIL miso_oe_active mode%0d: got %b, expected 1", m, miso_oe[m]); end
        spi_word(m, 8'h3C, 8, 1'b1, 1'b1, 8'hA5);
        cs_high(m);
        n_tests += 2;
        if (rxq.size() != 0)     begin n_fail++; $display("FAIL rx_missing mode%0d: %0d words pending, expected 0", m, rxq.size()); rxq.delete(); end
        if (miso_oe[m] !== 1'b0) begin n_fail++; $display("FAIL miso_oe_idle mode%0d: got %b, expected 0", m, miso_oe[m]); end
    endtask

    task automatic test_multi_word();
        cur = 1;
        und_cnt = 0;
        tx_put(1, 8'h11);
        cs_low(1);
        tx_put(1, 8'h22);
        spi_word(1, 8'h01, 8, 1'b1, 1'b1, 8'h11);
        spi_word(1, 8'h02, 8, 1'b1, 1'b1, 8'h22);
        spi_word(1, 8'h03, 8, 1'b1, 1'b1, 8'h00);
        cs_high(1);
        n_tests += 2;
        if (und_cnt != 1)    begin n_fail++; $display("FAIL tx_underrun_count: got %0d, expected 1", und_cnt); end
        if (rxq.size() != 0) begin n_fail++; $display("FAIL rx_missing_multi: %0d words pending, expected 0", rxq.size()); rxq.delete(); end
    endtask

    task automatic test_overrun();
        cur = 0;
        ovr_cnt = 0;
        rx_ready[0] = 1'b0;
        cs_low(0);
        spi_word(0, 8'h55, 8, 1'b0, 1'b1, 8'h00);
        spi_word(0, 8'hAA, 8, 1'b0, 1'b1, 8'h00);
        cs_high(0);
        n_tests += 3;
        if (rx_valid[0] !== 1'b1) begin n_fail++; $display("FAIL ovr_rx_valid: got %b, expected 1", rx_valid[0]); end
        if (rx_data[0] !== 8'hAA) begin n_fail++; $display("FAIL ovr_rx_data: got %h, expected aa", rx_data[0]); end
        if (ovr_cnt != 1)         begin n_fail++; $display("FAIL rx_overrun_count: got %0d, expected 1", ovr_cnt); end
        rxq.push_back(8'hAA);
        rx_ready[0] = 1'b1;
        repeat (4) @(negedge clk);
        n_tests += 2;
        if (rxq.size() != 0)      begin n_fail++; $display("FAIL ovr_drain: %0d words pending, expected 0", rxq.size()); rxq.delete(); end
        if (rx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ovr_rx_valid_clear: got %b, expected 0", rx_valid[0]); end
    endtask

    task automatic test_abort();
        cur = 0;
        cs_low(0);
        spi_word(0, 8'hFF, 5, 1'b0, 1'b0, 8'h00);
        cs_high(0);
        n_tests++;
        if (rx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL abort_rx_valid: got %b, expected 0", rx_valid[0]); end
        cs_low(0);
        spi_word(0, 8'hF0, 8, 1'b1, 1'b1, 8'h00);
        cs_high(0);
        n_tests++;
        if (rxq.size() != 0) begin n_fail++; $display("FAIL abort_next_frame: %0d words pending, expected 0", rxq.size()); rxq.delete(); end
    endtask

    task automatic test_rst_midframe();
        cur = 0;
        cs_low(0);
        spi_word(0, 8'hC3, 3, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests += 2;
        if (miso_oe[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso_oe: got %b, expected 0", miso_oe[0]); end
        if (miso[0] !== 1'b0)    begin n_fail++; $display("FAIL rstmid_miso: got %b, expected 0", miso[0]); end
        rst = 1'b0;
        spi_word(0, 8'h5A, 8, 1'b0, 1'b0, 8'h00);
        n_tests += 2;
        if (miso_oe[0] !== 1'b0)  begin n_fail++; $display("FAIL rstmid_no_resume: miso_oe=%b, expected 0", miso_oe[0]); end
        if (rx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b, expected 0", rx_valid[0]); end
        cs_high(0);
    endtask

`ifdef SPI_SLAVE_LSB_FIRST_EN
    task automatic test_lsb_first();
        cur = 0;
        tx_put(0, 8'h01);
        cs_low(0);
        n_tests++;
        if (miso[0] !== 1'b1) begin n_fail++; $display("FAIL lsb_first_bit: got %b, expected 1", miso[0]); end
        spi_word(0, 8'h80, 8, 1'b1, 1'b1, 8'h01);
        cs_high(0);
        n_tests++;
        if (rxq.size() != 0) begin n_fail++; $display("FAIL lsb_rx_missing: %0d words pending, expected 0", rxq.size()); rxq.delete(); end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        sclk     = 4'b1100;
        cs_n     = 4'b1111;
        mosi     = '0;
        tx_valid = '0;
        tx_data  = '0;
        rx_ready = 4'b1111;
        repeat (4) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) test_single_word(m);
        test_multi_word();
        test_overrun();
        test_abort();
        test_rst_midframe();
`ifdef SPI_SLAVE_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
